// File: rtl/std_mem_d1_arbiter_if.sv
// Request/memory bundle between NUM_REQ go/done requesters, the arbiter and one std_mem_d1.
// The slave modport is the arbiter's view; master is the requester-plus-memory side.
interface std_mem_d1_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4,
    parameter int NUM_REQ  = 4
);
    logic [NUM_REQ-1:0]          req_go;
    logic [NUM_REQ-1:0]          req_write_en;
    logic [NUM_REQ*IDX_SIZE-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]    req_write_data;
    logic [WIDTH-1:0]            req_read_data;
    logic [NUM_REQ-1:0]          req_done;
    logic [IDX_SIZE-1:0]         mem_addr0;
    logic [WIDTH-1:0]            mem_write_data;
    logic                        mem_write_en;
    logic [WIDTH-1:0]            mem_read_data;
    logic                        mem_done;

    modport slave (
        input  req_go, req_write_en, req_addr, req_write_data, mem_read_data, mem_done,
        output req_read_data, req_done, mem_addr0, mem_write_data, mem_write_en
    );

    modport master (
        output req_go, req_write_en, req_addr, req_write_data, mem_read_data, mem_done,
        input  req_read_data, req_done, mem_addr0, mem_write_data, mem_write_en
    );
endinterface

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin arbiter/sequencer sharing one std_mem_d1 among NUM_REQ go/done requesters.
// One transaction in flight; memory ports are driven from request fields latched at grant.
module std_mem_d1_arbiter #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4,
    parameter int NUM_REQ  = 4
) (
    input  logic                clk,
    input  logic                reset,
    std_mem_d1_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("std_mem_d1_arbiter: NUM_REQ must be in 2..8");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    grant_q;
    logic [IDX_SIZE-1:0] addr_q;
    logic [WIDTH-1:0]    wdata_q;
    logic [WIDTH-1:0]    rdata_q;
    logic                mem_we_q;
    logic [NUM_REQ-1:0]  done_q;

    logic                found_s;
    logic [PTR_W-1:0]    cand_s;
    logic [PTR_W-1:0]    sel_s;
    logic [IDX_SIZE-1:0] sel_addr_s;
    logic [WIDTH-1:0]    sel_wdata_s;
    logic                sel_op_s;
    logic [NUM_REQ-1:0]  grant_oh_s;
    logic [PTR_W-1:0]    ptr_next_s;

    // Round-robin pick: first asserted go scanning ptr_q, ptr_q+1, ... modulo NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        cand_s  = {PTR_W{1'b0}};
        sel_s   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s  = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            sel_s   = (!found_s && bus.req_go[cand_s]) ? cand_s : sel_s;
            found_s = found_s | bus.req_go[cand_s];
        end
    end

    assign sel_addr_s  = bus.req_addr[int'(sel_s)*IDX_SIZE +: IDX_SIZE];
    assign sel_wdata_s = bus.req_write_data[int'(sel_s)*WIDTH +: WIDTH];
    assign sel_op_s    = bus.req_write_en[sel_s];
    assign grant_oh_s  = NUM_REQ'(1) << grant_q;
    assign ptr_next_s  = (int'(grant_q) == NUM_REQ - 1) ? {PTR_W{1'b0}} : grant_q + PTR_W'(1);

    // Sequencer FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= {PTR_W{1'b0}};
            grant_q  <= {PTR_W{1'b0}};
            addr_q   <= {IDX_SIZE{1'b0}};
            wdata_q  <= {WIDTH{1'b0}};
            rdata_q  <= {WIDTH{1'b0}};
            mem_we_q <= 1'b0;
            done_q   <= {NUM_REQ{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_s) begin
                        grant_q <= sel_s;
                        addr_q  <= sel_addr_s;
                        wdata_q <= sel_wdata_s;
                        if (sel_op_s) begin
                            state_q  <= S_WRITE;
                            mem_we_q <= 1'b1;
                        end else begin
                            state_q  <= S_READ;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    rdata_q <= bus.mem_read_data;
                    done_q  <= grant_oh_s;
                    state_q <= S_DONE;
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                // No timeout: the memory is trusted to answer eventually.
                S_WAIT: begin
                    if (bus.mem_done) begin
                        done_q  <= grant_oh_s;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    done_q  <= {NUM_REQ{1'b0}};
                    ptr_q   <= ptr_next_s;
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    done_q   <= {NUM_REQ{1'b0}};
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_read_data  = rdata_q;
    assign bus.req_done       = done_q;
    assign bus.mem_addr0      = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_write_en   = mem_we_q;
endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// Bench for std_mem_d1_arbiter: directed scenarios plus random traffic against a
// transaction-level model (round-robin choice, fixed latencies, array memory).
module tb_std_mem_d1_arbiter;
    localparam int WIDTH    = 32;
    localparam int IDX_SIZE = 4;
    localparam int NUM_REQ  = 4;
    localparam int DEPTH    = 1 << IDX_SIZE;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    std_mem_d1_arbiter_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE), .NUM_REQ(NUM_REQ)) bus ();

    std_mem_d1_arbiter #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE), .NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Memory stub: combinational read, registered write, done mem_dly cycles after write_en.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
    int   mem_dly = 1;
    int   pend    = 0;
    logic spur    = 1'b0;
    assign bus.mem_read_data = mem[bus.mem_addr0];
    assign bus.mem_done      = (pend == 1) || spur;
    always @(posedge clk) begin
        if (reset) pend <= 0;
        else if (bus.mem_write_en) begin
            mem[bus.mem_addr0] <= bus.mem_write_data;
            pend <= mem_dly;
        end else if (pend != 0) pend <= pend - 1;
    end

    // Requester intents
    bit                  active [NUM_REQ];
    bit                  hold   [NUM_REQ];
    bit                  op     [NUM_REQ];
    logic [IDX_SIZE-1:0] addr   [NUM_REQ];
    logic [WIDTH-1:0]    wdata  [NUM_REQ];

    // Reference model
    int               cyc = 0;
    bit               busy = 1'b0;
    int               g = 0;
    bit               g_op = 1'b0;
    logic [IDX_SIZE-1:0] g_addr = '0;
    logic [WIDTH-1:0] g_wdata = '0, g_rdata = '0, exp_rdata = '0;
    int               done_cyc = -1, wen_cyc = -1, rd_cyc = -1;
    int               ptr = 0;
    logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
    bit               rst_req = 1'b1, rst_prev = 1'b1, spur_en = 1'b0;
    int               obs_q[$];
    int               obs_cyc = 0, wen_cnt = 0, t0 = 0;
    int               n_checks = 0, n_pass = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit any_active();
        bit a = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) a |= active[i];
        return a;
    endfunction

    task automatic step();
        bit was_busy;
        bit found;
        logic [NUM_REQ-1:0] exp_done;
        @(negedge clk);
        cyc++;
        was_busy = busy;
        exp_done = '0;
        if (busy && cyc == done_cyc) begin
            exp_done[g] = 1'b1;
            if (!g_op) exp_rdata = g_rdata;
            busy = 1'b0;
            ptr  = (g + 1) % NUM_REQ;
            if (!hold[g]) active[g] = 1'b0;
        end
        chk_eq("req_done", bus.req_done, exp_done);
        chk_eq("mem_write_en", bus.mem_write_en, was_busy && cyc == wen_cyc);
        chk_eq("req_read_data", bus.req_read_data, exp_rdata);
        if (was_busy && (cyc == wen_cyc || cyc == rd_cyc)) chk_eq("mem_addr0", bus.mem_addr0, g_addr);
        if (was_busy && cyc == wen_cyc) chk_eq("mem_write_data", bus.mem_write_data, g_wdata);
        if (rst_prev) begin
            chk_eq("rst_addr0", bus.mem_addr0, 0);
            chk_eq("rst_wdata", bus.mem_write_data, 0);
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_done[i]) begin obs_q.push_back(i); obs_cyc = cyc; end
        if (bus.mem_write_en) wen_cnt++;

        reset    = rst_req;
        rst_prev = rst_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_go[i]                              = active[i];
            bus.req_write_en[i]                        = op[i];
            bus.req_addr[i*IDX_SIZE +: IDX_SIZE]       = addr[i];
            bus.req_write_data[i*WIDTH +: WIDTH]       = wdata[i];
        end

        if (rst_req) begin
            busy = 1'b0; ptr = 0; exp_rdata = '0;
        end else if (!was_busy) begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                int i = (ptr + k) % NUM_REQ;
                if (!found && active[i]) begin found = 1'b1; g = i; end
            end
            if (found) begin
                busy = 1'b1; g_op = op[g]; g_addr = addr[g]; g_wdata = wdata[g];
                if (g_op) begin
                    wen_cyc = cyc + 1; rd_cyc = -1; done_cyc = cyc + 2 + mem_dly;
                    ref_mem[g_addr] = g_wdata;
                end else begin
                    rd_cyc = cyc + 1; wen_cyc = -1; done_cyc = cyc + 2;
                    g_rdata = ref_mem[g_addr];
                end
            end
        end
        // Spurious mem_done is only legal when the arbiter is not waiting on a write.
        spur = spur_en && ($urandom_range(3) == 0) &&
               !(busy && g_op && cyc > wen_cyc && cyc < done_cyc);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || any_active()) && n < max) begin step(); n++; end
        if (n >= max) chk_eq("idle_timeout", n, max - 1);
    endtask

    task automatic do_reset();
        rst_req = 1'b1; step(); step(); rst_req = 1'b0;
    endtask

    initial begin
        int exp_c[3] = '{2, 3, 0};
        int exp_f[4] = '{2, 1, 2, 1};
        bus.req_go = '0; bus.req_write_en = '0; bus.req_addr = '0; bus.req_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active[i] = 0; hold[i] = 0; op[i] = 0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) step();
        rst_req = 1'b0;

        // Write then read back through requester 0
        op[0] = 1; addr[0] = 4'd5; wdata[0] = 32'hDEADBEEF; active[0] = 1;
        t0 = cyc + 1; wen_cnt = 0;
        wait_idle(20);
        chk_eq("wr_latency", obs_cyc - t0, 3);
        chk_eq("wr_wen_cycles", wen_cnt, 1);
        op[0] = 0; active[0] = 1; t0 = cyc + 1;
        wait_idle(20);
        chk_eq("rd_latency", obs_cyc - t0, 2);
        chk_eq("rd_data", bus.req_read_data, 32'hDEADBEEF);

        // All four read at once after reset: order 0,1,2,3
        do_reset();
        obs_q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            op[i] = 0; addr[i] = IDX_SIZE'($urandom_range(DEPTH - 1)); active[i] = 1;
        end
        wait_idle(60);
        for (int i = 0; i < NUM_REQ; i++)
            chk_eq("order_all", (i < obs_q.size()) ? obs_q[i] : -1, i);

        // Grant 2 leaves ptr at 3, so 3 beats 0
        obs_q.delete();
        active[2] = 1; wait_idle(20);
        active[0] = 1; active[3] = 1; wait_idle(40);
        for (int i = 0; i < 3; i++)
            chk_eq("order_wrap", (i < obs_q.size()) ? obs_q[i] : -1, exp_c[i]);

        // Slow memory: mem_done three cycles after write_en
        mem_dly = 3; op[1] = 1; addr[1] = 4'd9; wdata[1] = 32'h1234_5678; active[1] = 1;
        t0 = cyc + 1; wen_cnt = 0;
        wait_idle(30);
        chk_eq("slow_wr_latency", obs_cyc - t0, 5);
        chk_eq("slow_wr_wen_cycles", wen_cnt, 1);

        // Reset while requester 1 sits in WAIT; it must be served once afterwards
        obs_q.delete();
        op[1] = 1; addr[1] = 4'd3; wdata[1] = 32'hCAFE_F00D; active[1] = 1; t0 = cyc + 1;
        while (cyc < t0 + 2) step();
        rst_req = 1'b1; step(); rst_req = 1'b0;
        wait_idle(30);
        chk_eq("abort_served_cnt", obs_q.size(), 1);
        chk_eq("abort_served_id", (obs_q.size() > 0) ? obs_q[0] : -1, 1);
        mem_dly = 1;

        // Requesters 2 (read) and 1 (write) both hold go: they alternate
        obs_q.delete();
        op[2] = 0; addr[2] = 4'd5; hold[2] = 1; active[2] = 1;
        op[1] = 1; addr[1] = 4'd7; wdata[1] = 32'h0BAD_F00D; hold[1] = 1; active[1] = 1;
        for (int n = 0; n < 80 && obs_q.size() < 4; n++) step();
        hold[1] = 0; hold[2] = 0; active[1] = 0; active[2] = 0;
        wait_idle(30);
        for (int i = 0; i < 4; i++)
            chk_eq("order_hold", (i < obs_q.size()) ? obs_q[i] : -1, exp_f[i]);

        // Random traffic, random field churn, spurious mem_done outside WAIT
        spur_en = 1'b1;
        repeat (600) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!active[i] && $urandom_range(3) == 0) begin
                    op[i] = 1'($urandom_range(1)); addr[i] = IDX_SIZE'($urandom_range(DEPTH - 1));
                    wdata[i] = $urandom; hold[i] = ($urandom_range(7) == 0); active[i] = 1;
                end else if (active[i] && $urandom_range(7) == 0) begin
                    addr[i] = IDX_SIZE'($urandom_range(DEPTH - 1)); wdata[i] = $urandom;
                end
                if (hold[i] && $urandom_range(15) == 0) hold[i] = 0;
            end
            if (!busy) mem_dly = $urandom_range(3, 1);
            step();
        end
        spur_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) hold[i] = 0;
        wait_idle(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/std_mem_d1_arbiter.md
Name: std_mem_d1_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port 1-D memory (combinational read, registered write, `done` one cycle after `write_en`) among NUM_REQ requesters.
- Each requester uses the go/done handshake of the memory-side components.
- The block serialises accesses, drives the memory ports from latched request fields, captures read data, and pulses a per-requester done.
- It sits between generated control groups and a shared memory instance.

Parameters:
- WIDTH, 32, data word width.
- IDX_SIZE, 4, address width.
- NUM_REQ, 4, number of requesters. Legal range 2..8; out-of-range values raise an elaboration $error.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- req_go  input  NUM_REQ  per-requester request. Held high until that requester's done.
- req_write_en  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*IDX_SIZE  flattened addresses. Requester i occupies bits [i*IDX_SIZE +: IDX_SIZE].
- req_write_data  input  NUM_REQ*WIDTH  flattened write data. Requester i occupies bits [i*WIDTH +: WIDTH].
- req_read_data  output  WIDTH  shared captured read data.
- req_done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- mem_addr0  output  IDX_SIZE  to memory addr0.
- mem_write_data  output  WIDTH  to memory write_data.
- mem_write_en  output  1  to memory write_en.
- mem_read_data  input  WIDTH  from memory read_data.
- mem_done  input  1  from memory done.

Behaviour:
- Reset, applied on any clock edge with reset=1, including mid-transaction:
  - state=IDLE, ptr=0, grant=0, latched addr/data/op=0, rdata=0.
  - All outputs 0 from that edge on: req_done=0, mem_write_en=0, mem_addr0=0, mem_write_data=0, req_read_data=0.
  - An aborted request is not completed; its requester must still hold go and will be re-arbitrated after reset.
- State machine:
  - IDLE: if req_go != 0, select the first asserted index searching ptr, ptr+1, ... wrapping modulo NUM_REQ. Latch grant, req_addr, req_write_data and req_write_en of that index. Next state is WRITE if the op is 1, else READ. Otherwise stay in IDLE.
  - READ (1 cycle): mem_addr0 = latched addr; rdata <= mem_read_data; next state DONE.
  - WRITE (1 cycle): mem_write_en=1 with latched addr/data; next state WAIT.
  - WAIT: mem_write_en=0; stay until mem_done=1 is sampled, then go to DONE. There is no timeout.
  - DONE (1 cycle): req_done[grant]=1 and all other bits 0; ptr <= (grant+1) mod NUM_REQ; next state IDLE.
- Outputs:
  - mem_write_en is high only in WRITE.
  - mem_addr0 and mem_write_data always show the latched values.
  - req_read_data = rdata. It is updated only in READ and holds until the next read, so writes do not disturb it.
- Latency with go sampled in IDLE at cycle 0:
  - Read: done at cycle 2.
  - Write with a standard memory (mem_done at cycle 2): done at cycle 3. Each extra cycle of mem_done delay adds one.
- Input sampling:
  - req_go and the request fields are sampled only in IDLE. Changes during a transaction are ignored.
  - A requester that keeps go high in the cycle after its done is treated as a new request in IDLE. It is subject to round-robin, so it yields to others.
- Fairness: a waiting requester is granted within NUM_REQ-1 completed transactions.
- Throughput: at most one transaction in flight. A minimum of one IDLE cycle separates transactions.
- Simultaneous requests: only one grant per IDLE cycle. The others stay pending with go held.
- mem_done outside WAIT is ignored.

Test Plan:
- Requester 0 writes 0xDEADBEEF to addr 5, then requester 0 reads addr 5 → mem_write_en high exactly 1 cycle (cycle 1); req_done[0] at cycle 3; read done 2 cycles after go; req_read_data=0xDEADBEEF.
- All 4 requesters assert go (reads) simultaneously, each holding go until its done → grants in order 0,1,2,3; each req_done one-hot; ptr wraps to 0.
- ptr=3 after a grant to 2; requesters 0 and 3 request simultaneously → 3 is granted first, then 0.
- Memory stub delays mem_done 3 cycles after write_en → arbiter stays in WAIT; done exactly 1 cycle after mem_done sampled; mem_write_en not re-asserted.
- Reset asserted in WAIT of a write by requester 1 → next edge: all outputs 0, ptr=0; with go still held, requester 1 is re-served after reset deasserts.
- Requester 2 holds go continuously while requester 1 also requests → requests alternate 2,1,2,1; no starvation; req_read_data is unchanged by intervening writes.
